// File: rtl/cmn_funnel_pkg.sv
// Shared definitions for the round-robin message funnel.
//   lock_state_e  : packet lock state (free arbitration vs. held by one input)
//   onehot_to_idx : OR-based one-hot to binary encoder over a fixed maximum width
package cmn_funnel_pkg;

  // Upper bound on the number of funnel inputs handled by the encoder.
  localparam int unsigned MaxReqs = 32;

  typedef enum logic [0:0] {
    Unlocked,
    Locked
  } lock_state_e;

  // Input must be one-hot or zero; zero encodes to index 0.
  function automatic int unsigned onehot_to_idx(input logic [MaxReqs-1:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MaxReqs; i++) begin
      if (onehot[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/cmn_rr_funnel_arb.sv
// Round-robin arbiter with packet locking for cmn_rr_funnel.
//   clk, reset : clock, asynchronous active-low reset
//   reqs       : per-input request (istream_val)
//   last       : per-input last-beat flag
//   accept_en  : downstream can take a beat this cycle
//   grants     : one-hot grant (zero when nothing is eligible)
//   grant_idx  : binary index of the granted input
module cmn_rr_funnel_arb
  import cmn_funnel_pkg::*;
#(
  parameter int unsigned p_num_reqs = 4,
  localparam int unsigned p_src_nbits = $clog2(p_num_reqs)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [p_num_reqs-1:0]  reqs,
  input  logic [p_num_reqs-1:0]  last,
  input  logic                   accept_en,
  output logic [p_num_reqs-1:0]  grants,
  output logic [p_src_nbits-1:0] grant_idx
);

  logic [p_num_reqs-1:0]  prio_q, prio_d;
  lock_state_e            lock_state_q, lock_state_d;
  logic [p_src_nbits-1:0] lock_idx_q, lock_idx_d;

  logic [p_num_reqs-1:0]  rr_grant;
  logic [p_num_reqs-1:0]  lock_mask;
  logic [MaxReqs-1:0]     prio_wide, grant_wide;
  logic [p_src_nbits-1:0] prio_idx;
  logic [p_src_nbits-1:0] scan_idx;
  int unsigned            scan_pos;
  logic                   found;
  logic                   accept;

  // Round-robin: scan upward from the highest-priority input, wrapping at p_num_reqs.
  always_comb begin
    prio_wide                   = '0;
    prio_wide[p_num_reqs-1:0]   = prio_q;
    prio_idx                    = p_src_nbits'(onehot_to_idx(prio_wide));
    rr_grant                    = '0;
    found                       = 1'b0;
    scan_pos                    = 0;
    scan_idx                    = '0;
    for (int unsigned k = 0; k < p_num_reqs; k++) begin
      scan_pos = 32'(prio_idx) + k;
      if (scan_pos >= p_num_reqs) scan_pos = scan_pos - p_num_reqs;
      scan_idx = p_src_nbits'(scan_pos);
      if (!found && reqs[scan_idx]) begin
        rr_grant[scan_idx] = 1'b1;
        found              = 1'b1;
      end
    end
  end

  // While a packet is open only its owner may be granted, even if it goes idle.
  always_comb begin
    lock_mask             = '0;
    lock_mask[lock_idx_q] = 1'b1;
    grants                = (lock_state_q == Locked) ? (lock_mask & reqs) : rr_grant;
    grant_wide                 = '0;
    grant_wide[p_num_reqs-1:0] = grants;
    grant_idx                  = p_src_nbits'(onehot_to_idx(grant_wide));
    accept                     = (|grants) && accept_en;
  end

  always_comb begin
    prio_d       = prio_q;
    lock_state_d = lock_state_q;
    lock_idx_d   = lock_idx_q;
    if (accept) begin
      // Winner drops to lowest priority.
      prio_d = {grants[p_num_reqs-2:0], grants[p_num_reqs-1]};
      unique case (lock_state_q)
        Unlocked: begin
          if (!last[grant_idx]) begin
            lock_state_d = Locked;
            lock_idx_d   = grant_idx;
          end
        end
        Locked: begin
          if (last[grant_idx]) lock_state_d = Unlocked;
        end
        default: lock_state_d = Unlocked;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q       <= p_num_reqs'(1);
      lock_state_q <= Unlocked;
      lock_idx_q   <= '0;
    end else begin
      prio_q       <= prio_d;
      lock_state_q <= lock_state_d;
      lock_idx_q   <= lock_idx_d;
    end
  end

endmodule

// File: rtl/cmn_rr_funnel.sv
// N-to-1 valid/ready message funnel with round-robin fairness and packet locking.
// The winning input's beat is registered into a one-entry output stage and tagged
// with its source index.
//   clk, reset                  : clock, asynchronous active-low reset
//   istream_val/rdy/msg/last    : N input streams (msg flattened, input i at [i*W +: W])
//   ostream_val/rdy/msg/src/last: registered output stream with source tag
module cmn_rr_funnel
  import cmn_funnel_pkg::*;
#(
  parameter int unsigned p_num_reqs  = 4,
  parameter int unsigned p_msg_nbits = 32,
  localparam int unsigned p_src_nbits = $clog2(p_num_reqs)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [p_num_reqs-1:0]             istream_val,
  output logic [p_num_reqs-1:0]             istream_rdy,
  input  logic [p_num_reqs*p_msg_nbits-1:0] istream_msg,
  input  logic [p_num_reqs-1:0]             istream_last,
  output logic                              ostream_val,
  input  logic                              ostream_rdy,
  output logic [p_msg_nbits-1:0]            ostream_msg,
  output logic [p_src_nbits-1:0]            ostream_src,
  output logic                              ostream_last
);

  logic                   ostream_val_q, ostream_val_d;
  logic [p_msg_nbits-1:0] ostream_msg_q, ostream_msg_d;
  logic [p_src_nbits-1:0] ostream_src_q, ostream_src_d;
  logic                   ostream_last_q, ostream_last_d;

  logic                   can_accept;
  logic                   accept;
  logic [p_num_reqs-1:0]  grants;
  logic [p_src_nbits-1:0] grant_idx;
  logic [p_msg_nbits-1:0] sel_msg;

  cmn_rr_funnel_arb #(
    .p_num_reqs (p_num_reqs)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .reqs      (istream_val),
    .last      (istream_last),
    .accept_en (can_accept),
    .grants    (grants),
    .grant_idx (grant_idx)
  );

  // Reset is folded in so no input sees rdy while the funnel is held in reset.
  always_comb begin
    can_accept  = reset && (!ostream_val_q || ostream_rdy);
    accept      = (|grants) && can_accept;
    istream_rdy = grants & {p_num_reqs{can_accept}};
  end

  // Grants are one-hot, so an OR-free priority mux is sufficient.
  always_comb begin
    sel_msg = '0;
    for (int unsigned i = 0; i < p_num_reqs; i++) begin
      if (grants[i]) sel_msg = istream_msg[i*p_msg_nbits +: p_msg_nbits];
    end
  end

  always_comb begin
    ostream_val_d  = ostream_val_q;
    ostream_msg_d  = ostream_msg_q;
    ostream_src_d  = ostream_src_q;
    ostream_last_d = ostream_last_q;
    if (accept) begin
      ostream_val_d  = 1'b1;
      ostream_msg_d  = sel_msg;
      ostream_src_d  = grant_idx;
      ostream_last_d = istream_last[grant_idx];
    end else if (ostream_rdy) begin
      ostream_val_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ostream_val_q  <= 1'b0;
      ostream_msg_q  <= '0;
      ostream_src_q  <= '0;
      ostream_last_q <= 1'b0;
    end else begin
      ostream_val_q  <= ostream_val_d;
      ostream_msg_q  <= ostream_msg_d;
      ostream_src_q  <= ostream_src_d;
      ostream_last_q <= ostream_last_d;
    end
  end

  assign ostream_val  = ostream_val_q;
  assign ostream_msg  = ostream_msg_q;
  assign ostream_src  = ostream_src_q;
  assign ostream_last = ostream_last_q;

endmodule

// File: tb/tb_cmn_rr_funnel.sv
// Self-checking bench for cmn_rr_funnel (4 inputs, 32-bit messages).
module tb_cmn_rr_funnel;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk;
  logic           reset;
  logic [N-1:0]   istream_val;
  logic [N-1:0]   istream_rdy;
  logic [N*W-1:0] istream_msg;
  logic [N-1:0]   istream_last;
  logic           ostream_val;
  logic           ostream_rdy;
  logic [W-1:0]   ostream_msg;
  logic [1:0]     ostream_src;
  logic           ostream_last;

  int checks;
  int passed;

  // Reference model state: output slot contents, rotating pointer, packet owner.
  bit         m_val;
  logic [W-1:0] m_msg;
  int         m_src;
  bit         m_last;
  int         m_ptr;
  bit         m_locked;
  int         m_owner;
  bit         m_in_reset;

  logic [N-1:0] exp_rdy;

  cmn_rr_funnel #(
    .p_num_reqs  (N),
    .p_msg_nbits (W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .istream_val  (istream_val),
    .istream_rdy  (istream_rdy),
    .istream_msg  (istream_msg),
    .istream_last (istream_last),
    .ostream_val  (ostream_val),
    .ostream_rdy  (ostream_rdy),
    .ostream_msg  (ostream_msg),
    .ostream_src  (ostream_src),
    .ostream_last (ostream_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_val      = 1'b0;
    m_msg      = '0;
    m_src      = 0;
    m_last     = 1'b0;
    m_ptr      = 0;
    m_locked   = 1'b0;
    m_owner    = 0;
    m_in_reset = 1'b1;
  endtask

  // Which input the funnel should take this cycle, or -1.
  function automatic int model_accept_idx();
    if (m_in_reset) return -1;
    if (m_val && !ostream_rdy) return -1;
    if (m_locked) return istream_val[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      if (istream_val[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_rdy();
    int w;
    w = model_accept_idx();
    if (w < 0) return '0;
    return N'(1 << w);
  endfunction

  task automatic model_step();
    int w;
    w = model_accept_idx();
    if (w >= 0) begin
      m_val  = 1'b1;
      m_msg  = istream_msg[w*W +: W];
      m_src  = w;
      m_last = istream_last[w];
      m_ptr  = (w + 1) % N;
      if (!m_locked && !istream_last[w]) begin
        m_locked = 1'b1;
        m_owner  = w;
      end else if (m_locked && istream_last[w]) begin
        m_locked = 1'b0;
      end
    end else if (ostream_rdy && !m_in_reset) begin
      m_val = 1'b0;
    end
  endtask

  // Applies inputs at the falling edge with fresh random messages, then settles.
  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic r);
    @(negedge clk);
    istream_val  = v;
    istream_last = l;
    ostream_rdy  = r;
    for (int i = 0; i < N; i++) istream_msg[i*W +: W] = $urandom;
    #1;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    istream_val  = '1;
    istream_last = '1;
    ostream_rdy  = 1'b1;
    istream_msg  = '0;
    #3 reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      drive('1, '1, 1'b1);
      checks++;
      if (ostream_val !== 1'b0 || istream_rdy !== 4'b0000 || ostream_msg !== '0 ||
          ostream_src !== 2'd0 || ostream_last !== 1'b0)
        $display("FAIL reset_hold c%0d: val=%b rdy=%b msg=%h src=%0d last=%b required 0 0000 0 0 0",
                 c, ostream_val, istream_rdy, ostream_msg, ostream_src, ostream_last);
      else passed++;
      model_step();
    end
    @(negedge clk);
    reset = 1'b1;
    m_in_reset = 1'b0;
    #1;
    checks++;
    if (istream_rdy !== 4'b0001)
      $display("FAIL reset_first_grant: rdy=%b required 0001", istream_rdy);
    else passed++;
    model_step();
    drive('1, '1, 1'b1);
    checks++;
    if (ostream_val !== 1'b1 || ostream_src !== 2'd0 || ostream_msg !== m_msg)
      $display("FAIL reset_first_beat: val=%b src=%0d msg=%h required 1 0 %h",
               ostream_val, ostream_src, ostream_msg, m_msg);
    else passed++;
    model_step();
  endtask

  task automatic test_round_robin();
    for (int c = 0; c < 9; c++) begin
      drive('1, '1, 1'b1);
      exp_rdy = model_rdy();
      checks++;
      if (istream_rdy !== exp_rdy || ostream_val !== m_val ||
          (m_val && (ostream_msg !== m_msg || ostream_src !== 2'(m_src) || ostream_last !== m_last)))
        $display("FAIL rr c%0d: rdy=%b val=%b src=%0d msg=%h required rdy=%b val=%b src=%0d msg=%h",
                 c, istream_rdy, ostream_val, ostream_src, ostream_msg,
                 exp_rdy, m_val, m_src, m_msg);
      else passed++;
      model_step();
    end
  endtask

  task automatic test_packet_lock();
    logic [N-1:0] vals  [5] = '{4'b0001, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
    logic [N-1:0] lasts [5] = '{4'b1111, 4'b1101, 4'b1101, 4'b1111, 4'b1111};
    logic [N-1:0] rdys  [5] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
    for (int c = 0; c < 5; c++) begin
      drive(vals[c], lasts[c], 1'b1);
      exp_rdy = model_rdy();
      checks++;
      if (istream_rdy !== rdys[c] || istream_rdy !== exp_rdy || ostream_val !== m_val ||
          (m_val && (ostream_msg !== m_msg || ostream_src !== 2'(m_src) || ostream_last !== m_last)))
        $display("FAIL pkt c%0d: rdy=%b val=%b src=%0d msg=%h required rdy=%b val=%b src=%0d msg=%h",
                 c, istream_rdy, ostream_val, ostream_src, ostream_msg,
                 rdys[c], m_val, m_src, m_msg);
      else passed++;
      model_step();
    end
  endtask

  task automatic test_stall();
    for (int c = 0; c < 10; c++) begin
      drive('1, '1, (c < 2 || c >= 7));
      exp_rdy = model_rdy();
      checks++;
      if (istream_rdy !== exp_rdy || ostream_val !== m_val ||
          (m_val && (ostream_msg !== m_msg || ostream_src !== 2'(m_src) || ostream_last !== m_last)))
        $display("FAIL stall c%0d: rdy=%b val=%b src=%0d msg=%h required rdy=%b val=%b src=%0d msg=%h",
                 c, istream_rdy, ostream_val, ostream_src, ostream_msg,
                 exp_rdy, m_val, m_src, m_msg);
      else passed++;
      if (c >= 2 && c < 7) begin
        checks++;
        if (istream_rdy !== 4'b0000)
          $display("FAIL stall_rdy c%0d: rdy=%b required 0000", c, istream_rdy);
        else passed++;
      end
      model_step();
    end
  endtask

  task automatic test_lock_idle();
    logic [N-1:0] vals  [6] = '{4'b0100, 4'b1011, 4'b1011, 4'b1011, 4'b1111, 4'b1111};
    logic [N-1:0] lasts [6] = '{4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
    logic [N-1:0] rdys  [6] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000};
    for (int c = 0; c < 6; c++) begin
      drive(vals[c], lasts[c], 1'b1);
      exp_rdy = model_rdy();
      checks++;
      if (istream_rdy !== rdys[c] || istream_rdy !== exp_rdy || ostream_val !== m_val ||
          (m_val && (ostream_msg !== m_msg || ostream_src !== 2'(m_src) || ostream_last !== m_last)))
        $display("FAIL lock_idle c%0d: rdy=%b val=%b src=%0d required rdy=%b val=%b src=%0d",
                 c, istream_rdy, ostream_val, ostream_src, rdys[c], m_val, m_src);
      else passed++;
      model_step();
    end
  endtask

  task automatic test_async_reset();
    drive(4'b1000, 4'b0000, 1'b1);
    model_step();
    drive(4'b1000, 4'b0000, 1'b1);
    model_step();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (ostream_val !== 1'b0 || istream_rdy !== 4'b0000)
      $display("FAIL async_reset: val=%b rdy=%b required 0 0000", ostream_val, istream_rdy);
    else passed++;
    model_reset();
    @(negedge clk);
    istream_val  = '1;
    istream_last = '1;
    ostream_rdy  = 1'b1;
    reset        = 1'b1;
    m_in_reset   = 1'b0;
    #1;
    checks++;
    if (istream_rdy !== 4'b0001)
      $display("FAIL async_reset_grant: rdy=%b required 0001", istream_rdy);
    else passed++;
    model_step();
    drive('1, '1, 1'b1);
    checks++;
    if (ostream_val !== 1'b1 || ostream_src !== 2'd0 || istream_rdy !== 4'b0010)
      $display("FAIL async_reset_after: val=%b src=%0d rdy=%b required 1 0 0010",
               ostream_val, ostream_src, istream_rdy);
    else passed++;
    model_step();
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    logic [N-1:0] l;
    for (int c = 0; c < 400; c++) begin
      v = N'($urandom);
      l = ~N'($urandom & $urandom);
      drive(v, l, ($urandom_range(0, 3) != 0));
      exp_rdy = model_rdy();
      checks++;
      if (istream_rdy !== exp_rdy || ostream_val !== m_val ||
          (m_val && (ostream_msg !== m_msg || ostream_src !== 2'(m_src) || ostream_last !== m_last)))
        $display("FAIL random c%0d: rdy=%b val=%b src=%0d msg=%h last=%b required rdy=%b val=%b src=%0d msg=%h last=%b",
                 c, istream_rdy, ostream_val, ostream_src, ostream_msg, ostream_last,
                 exp_rdy, m_val, m_src, m_msg, m_last);
      else passed++;
      model_step();
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_stall();
    test_lock_idle();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
